vs_spi_responder: RTL
=====================

Name: vs_spi_responder

Overview:
- Decoder-side SPI responder that stands in for the VS10xx audio decoder on the board interface our MP3 streaming master drives.
- Receives SCI command frames on XCS and SDI data bytes on XDCS.
- Drives DREQ flow control and the SO read-back line.
- Hands received audio bytes to a downstream consumer through a valid/ready FIFO port; used for bench loop-back and as an on-chip sink.

Parameters:
- FIFO_DEPTH, 64, SDI byte FIFO depth; power of two, minimum 64.
- DREQ_SPACE, 32, minimum free FIFO bytes required for DREQ=1.
- RESET_HOLD, 1000, clk cycles DREQ is held low after a soft reset.
- SCI_BUSY, 8, clk cycles DREQ is held low after each committed SCI write.

Ports:
- clk  in  1  system clock; must be at least 4x the SCK frequency.
- rst  in  1  synchronous, active-high reset.
- i_XCS  in  1  SCI chip select, active low.
- i_XDCS  in  1  SDI data select, active low.
- i_SCK  in  1  SPI clock from the master.
- i_SI  in  1  serial data in, MSB first.
- o_SO  out  1  serial read data.
- o_DREQ  out  1  data request / ready.
- o_byte  out  8  FIFO head byte.
- o_byte_valid  out  1  FIFO non-empty.
- i_byte_ready  in  1  consumer accepts o_byte.
- o_vol  out  16  live copy of register 0xB.
- o_ovf  out  1  sticky SDI overflow flag.
- o_sdi_count  out  32  accepted SDI byte count (optional feature).

Behaviour:
- Reset values: o_SO=0, o_DREQ=0, o_byte_valid=0, o_ovf=0, o_vol=0x0000, o_sdi_count=0, FIFO empty, register MODE(0x0)=0x0800, all other registers 0. o_DREQ rises on the first cycle after reset ends if the FIFO has space.
- Input synchronisation: i_XCS, i_XDCS, i_SCK and i_SI each pass through a 2-flop synchroniser.
- SCK edges: a rise/fall of the synchronised SCK is detected against its previous value.
- SI sampling: on SCK rise; o_SO changes on SCK fall.
- Select priority: XCS low selects SCI; SDI is active only when XDCS is low and XCS is high. If both are low, SCI wins and SDI bits are ignored.
- SCI state machine: IDLE -> OPCODE (8 bits) -> ADDR (8 bits) -> DATA (16 bits) -> IDLE.
  - Opcode 0x02 is a write; the register is updated on the clk after the 32nd SCK rise.
  - Opcode 0x03 is a read; at the end of ADDR, the register value is loaded into the SO shifter, and its MSB is driven on the next SCK fall.
  - Any other opcode: DATA bits are ignored, no write, o_SO=0.
  - Address bits [7:4] != 0: write ignored, read returns 0x0000.
  - XCS rising mid-frame: frame discarded, bit count cleared, return to IDLE, o_SO=0.
- Soft reset: a write to MODE with bit 2 set flushes the FIFO, holds o_DREQ=0 for RESET_HOLD cycles, and stores MODE with bit 2 cleared.
- SCI write busy: o_DREQ=0 for SCI_BUSY cycles after each committed write. If the soft-reset hold and the busy hold overlap, the longer one governs.
- SDI: bytes are shifted in MSB first. After 8 bits the byte is pushed to the FIFO.
  - If the FIFO is full, the byte is dropped and o_ovf is set; o_ovf is cleared only by rst.
  - XDCS rising mid-byte discards the partial bits.
- o_DREQ = (free >= DREQ_SPACE) and no hold active; registered, 1-cycle latency from the FIFO level change.
- FIFO: first-word-fall-through. A pop occurs when o_byte_valid && i_byte_ready. Simultaneous push and pop when full: the pop frees space first, so the push succeeds.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- o_vol is updated in the same cycle that register 0xB is written.

Optional Feature:
- Macro RESPONDER_STATS_EN.
- Defined: o_sdi_count increments on each accepted (non-dropped) SDI byte, wraps at 2^32, and is cleared by rst or by a soft reset.
- Undefined: no counter logic is built and o_sdi_count is tied to 0.

Test Plan:
- SCI write frame 0x020B0000, then 0x020B2020 -> o_vol=0x0000, then 0x2020; o_DREQ low for 8 cycles after each write.
- SCI write 0x02000804 with 10 bytes in the FIFO -> FIFO empty, MODE reads back 0x0800 via frame 0x03000000 on SO; o_DREQ low for 1000 cycles.
- Read frame 0x030B0000 after volume 0x2020 -> SO bits 16..31 = 0x2020 MSB first; invalid address 0x0312xxxx -> SO all zero.
- i_byte_ready=0, stream SDI bytes 0x00..0x3F -> o_DREQ falls after the 33rd byte, FIFO holds 64 bytes, 65th byte dropped, o_ovf=1, o_sdi_count=64 with RESPONDER_STATS_EN.
- Raise i_XCS after 12 bits of frame 0x020B1234 -> o_vol unchanged; the next full frame is decoded correctly.
- XCS and XDCS both low, 8 SCK pulses -> no FIFO push; SCI opcode captured.

Source files
------------

// File: rtl/vs_spi_responder.sv
// SPI responder standing in for a VS10xx decoder: SCI register frames on XCS, SDI audio bytes on XDCS into a FWFT FIFO.
// Optional macro RESPONDER_STATS_EN builds the accepted-SDI-byte counter behind o_sdi_count.
module vs_spi_responder #(
  parameter int FIFO_DEPTH = 64,
  parameter int DREQ_SPACE = 32,
  parameter int RESET_HOLD = 1000,
  parameter int SCI_BUSY   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_XCS,
  input  logic        i_XDCS,
  input  logic        i_SCK,
  input  logic        i_SI,
  output logic        o_SO,
  output logic        o_DREQ,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic [15:0] o_vol,
  output logic        o_ovf,
  output logic [31:0] o_sdi_count
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int PW       = AW + 1;
  localparam int HOLD_MAX = (RESET_HOLD > SCI_BUSY) ? RESET_HOLD : SCI_BUSY;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam logic [PW-1:0] DEPTH_W = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] SPACE_W = PW'(DREQ_SPACE);

  typedef enum logic [1:0] {S_IDLE, S_OPCODE, S_ADDR, S_DATA} sci_state_t;

  // ---------------------------------------------------------------- input sync
  logic [1:0] xcs_q, xdcs_q, sck_q, si_q;
  logic       sck_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      xcs_q    <= 2'b11;
      xdcs_q   <= 2'b11;
      sck_q    <= 2'b00;
      si_q     <= 2'b00;
      sck_prev <= 1'b0;
    end else begin
      xcs_q    <= {xcs_q[0], i_XCS};
      xdcs_q   <= {xdcs_q[0], i_XDCS};
      sck_q    <= {sck_q[0], i_SCK};
      si_q     <= {si_q[0], i_SI};
      sck_prev <= sck_q[1];
    end
  end

  logic sck_rise, sck_fall, si_s, sci_sel, sdi_sel;
  assign sck_rise = sck_q[1] & ~sck_prev;
  assign sck_fall = ~sck_q[1] & sck_prev;
  assign si_s     = si_q[1];
  // SCI wins whenever XCS is low, so SDI needs XDCS low and XCS high.
  assign sci_sel  = ~xcs_q[1];
  assign sdi_sel  = ~xdcs_q[1] & xcs_q[1];

  // ---------------------------------------------------------------- SCI FSM
  sci_state_t  state, state_d;
  logic [3:0]  bit_cnt;
  logic [15:0] sci_sh;
  logic [15:0] so_shift;
  logic [7:0]  opcode, addr;
  logic        so_q;
  logic [15:0] regs [16];

  logic [15:0] sci_word;
  logic        shift_en, op_done, addr_done, data_done, wr_commit, soft_rst;
  logic [3:0]  wr_addr;

  assign sci_word = {sci_sh[14:0], si_s};
  assign wr_addr  = addr[3:0];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // NOTE: every signal assigned in a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    if (!sci_sel) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state_d = S_OPCODE;
        S_OPCODE: if (sck_rise && bit_cnt == 4'd7)  state_d = S_ADDR;
        S_ADDR:   if (sck_rise && bit_cnt == 4'd7)  state_d = S_DATA;
        S_DATA:   if (sck_rise && bit_cnt == 4'd15) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en  = sci_sel && sck_rise && (state != S_IDLE);
    op_done   = 1'b0;
    addr_done = 1'b0;
    data_done = 1'b0;
    case (state)
      S_OPCODE: op_done   = shift_en && (bit_cnt == 4'd7);
      S_ADDR:   addr_done = shift_en && (bit_cnt == 4'd7);
      S_DATA:   data_done = shift_en && (bit_cnt == 4'd15);
      default:  ;
    endcase
    wr_commit = data_done && (opcode == 8'h02) && (addr[7:4] == 4'h0);
    soft_rst  = wr_commit && (wr_addr == 4'h0) && sci_word[2];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      sci_sh   <= '0;
      opcode   <= '0;
      addr     <= '0;
      so_shift <= '0;
      so_q     <= 1'b0;
    end else if (!sci_sel || state == S_IDLE) begin
      bit_cnt  <= '0;
      so_shift <= '0;
      so_q     <= 1'b0;
    end else begin
      if (shift_en) begin
        sci_sh  <= sci_word;
        bit_cnt <= (op_done || addr_done || data_done) ? 4'd0 : bit_cnt + 4'd1;
      end
      if (op_done) opcode <= sci_word[7:0];
      if (addr_done) begin
        addr     <= sci_word[7:0];
        so_shift <= (opcode == 8'h03 && sci_word[7:4] == 4'h0) ? regs[sci_word[3:0]] : 16'h0000;
      end
      if (sck_fall) begin
        so_q     <= so_shift[15];
        so_shift <= {so_shift[14:0], 1'b0};
      end
    end
  end

  // Register file is only 16 words, so it is reset like ordinary state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
      regs[0] <= 16'h0800;
    end else if (wr_commit) begin
      regs[wr_addr] <= (wr_addr == 4'h0) ? (sci_word & ~16'h0004) : sci_word;
    end
  end

  assign o_SO  = so_q;
  assign o_vol = regs[11];

  // ---------------------------------------------------------------- SDI shifter
  logic [2:0] sdi_cnt;
  logic [7:0] sdi_sh;
  logic       push_req;
  logic [7:0] push_byte;

  always_ff @(posedge clk) begin
    if (rst || !sdi_sel) begin
      sdi_cnt <= '0;
      if (rst) sdi_sh <= '0;
    end else if (sck_rise) begin
      sdi_sh  <= {sdi_sh[6:0], si_s};
      sdi_cnt <= sdi_cnt + 3'd1;
    end
  end

  assign push_req  = sdi_sel && sck_rise && (sdi_cnt == 3'd7);
  assign push_byte = {sdi_sh[6:0], si_s};

  // ---------------------------------------------------------------- FIFO
  logic [PW-1:0] wr_ptr, rd_ptr, level, free;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          full, empty, pop, push_ok, ovf_q;

  assign level   = wr_ptr - rd_ptr;
  assign free    = DEPTH_W - level;
  assign full    = (level == DEPTH_W);
  assign empty   = (level == '0);
  assign pop     = !empty && i_byte_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (soft_rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_req && !push_ok) ovf_q <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok && !soft_rst) mem[wr_ptr[AW-1:0]] <= push_byte;
  end

  assign o_byte       = mem[rd_ptr[AW-1:0]];
  assign o_byte_valid = !empty;
  assign o_ovf        = ovf_q;

  // ---------------------------------------------------------------- DREQ
  logic [HW-1:0] hold_cnt, hold_dec, hold_load;
  logic          dreq_q;

  assign hold_dec  = (hold_cnt != '0) ? hold_cnt - 1'b1 : '0;
  // The commit cycle itself forces DREQ low, so the counter loads one less than the hold length.
  assign hold_load = soft_rst ? HW'(HOLD_MAX - 1) : HW'(SCI_BUSY - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      dreq_q   <= 1'b0;
    end else begin
      hold_cnt <= (wr_commit && hold_load > hold_dec) ? hold_load : hold_dec;
      dreq_q   <= !wr_commit && (hold_cnt == '0) && (free >= SPACE_W);
    end
  end

  assign o_DREQ = dreq_q;

  // ---------------------------------------------------------------- stats
`ifdef RESPONDER_STATS_EN
  logic [31:0] sdi_count_q;

  always_ff @(posedge clk) begin
    if (rst || soft_rst) sdi_count_q <= '0;
    else if (push_ok)    sdi_count_q <= sdi_count_q + 32'd1;
  end

  assign o_sdi_count = sdi_count_q;
`else
  assign o_sdi_count = 32'd0;
`endif

endmodule
